// File: rtl/vscale_hasti_sram_arbiter.sv
// rtl/vscale_hasti_sram_arbiter.sv - two-master round-robin HASTI arbiter in front of a single SRAM port
// Optional stall-cycle counters are built only when VSCALE_ARB_PERF_EN is defined.
module vscale_hasti_sram_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [31:0]      m0_haddr,
  input  logic             m0_hwrite,
  input  logic [2:0]       m0_hsize,
  input  logic [1:0]       m0_htrans,
  input  logic [31:0]      m0_hwdata,
  output logic [31:0]      m0_hrdata,
  output logic             m0_hready,
  output logic             m0_hresp,
  input  logic [31:0]      m1_haddr,
  input  logic             m1_hwrite,
  input  logic [2:0]       m1_hsize,
  input  logic [1:0]       m1_htrans,
  input  logic [31:0]      m1_hwdata,
  output logic [31:0]      m1_hrdata,
  output logic             m1_hready,
  output logic             m1_hresp,
  output logic [31:0]      s_haddr,
  output logic             s_hwrite,
  output logic [2:0]       s_hsize,
  output logic [1:0]       s_htrans,
  output logic [31:0]      s_hwdata,
  input  logic [31:0]      s_hrdata,
  input  logic             s_hready,
  input  logic             s_hresp,
  output logic [CNT_W-1:0] stall_cnt0,
  output logic [CNT_W-1:0] stall_cnt1
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  // Address phases that lost arbitration are parked here until granted.
  logic        pend0, pend1;
  logic [31:0] pend_addr0, pend_addr1;
  logic        pend_write0, pend_write1;
  logic [2:0]  pend_size0, pend_size1;

  owner_t dph_owner;
  logic   last_grant;  // 0: M0 was granted last, 1: M1 was granted last

  logic live0, live1, req0, req1, grant0, grant1;

  // Only htrans[1] distinguishes active from idle; SEQ/BUSY detail is dropped.
  logic unused_htrans;
  assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];

  // A master stalled in its data phase has hready low, so it cannot post a live request.
  assign m0_hready = !pend0 && ((dph_owner != OWN_M0) || s_hready);
  assign m1_hready = !pend1 && ((dph_owner != OWN_M1) || s_hready);

  assign live0 = m0_htrans[1] && m0_hready;
  assign live1 = m1_htrans[1] && m1_hready;
  assign req0  = pend0 || live0;
  assign req1  = pend1 || live1;

  // Grant only while the SRAM accepts an address; contention goes to the master not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (hresetn && s_hready) begin
      if (req0 && req1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Forward the granted address phase (parked copy first) as a NONSEQ single.
  always_comb begin
    s_haddr  = 32'h0;
    s_hwrite = 1'b0;
    s_hsize  = 3'b000;
    s_htrans = HTRANS_IDLE;
    if (grant0) begin
      s_haddr  = pend0 ? pend_addr0  : m0_haddr;
      s_hwrite = pend0 ? pend_write0 : m0_hwrite;
      s_hsize  = pend0 ? pend_size0  : m0_hsize;
      s_htrans = HTRANS_NONSEQ;
    end else if (grant1) begin
      s_haddr  = pend1 ? pend_addr1  : m1_haddr;
      s_hwrite = pend1 ? pend_write1 : m1_hwrite;
      s_hsize  = pend1 ? pend_size1  : m1_hsize;
      s_htrans = HTRANS_NONSEQ;
    end
  end

  // Data-phase routing follows the current data-phase owner.
  always_comb begin
    s_hwdata = 32'h0;
    case (dph_owner)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = 32'h0;
    endcase
  end

  assign m0_hresp  = (dph_owner == OWN_M0) && s_hresp;
  assign m1_hresp  = (dph_owner == OWN_M1) && s_hresp;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  // Park losing live requests, retire granted ones, and track arbitration/data-phase state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      pend_addr0  <= 32'h0;
      pend_addr1  <= 32'h0;
      pend_write0 <= 1'b0;
      pend_write1 <= 1'b0;
      pend_size0  <= 3'b000;
      pend_size1  <= 3'b000;
      dph_owner   <= OWN_NONE;
      last_grant  <= 1'b1;
    end else begin
      if (grant0) begin
        pend0 <= 1'b0;
      end else if (live0) begin
        pend0       <= 1'b1;
        pend_addr0  <= m0_haddr;
        pend_write0 <= m0_hwrite;
        pend_size0  <= m0_hsize;
      end
      if (grant1) begin
        pend1 <= 1'b0;
      end else if (live1) begin
        pend1       <= 1'b1;
        pend_addr1  <= m1_haddr;
        pend_write1 <= m1_hwrite;
        pend_size1  <= m1_hsize;
      end
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      if (s_hready) begin
        dph_owner <= grant0 ? OWN_M0 : (grant1 ? OWN_M1 : OWN_NONE);
      end
    end
  end

`ifdef VSCALE_ARB_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count cycles each master spends parked, saturating at all-ones.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
    end else begin
      if (pend0 && (stall_cnt0 != CNT_MAX)) stall_cnt0 <= stall_cnt0 + CNT_ONE;
      if (pend1 && (stall_cnt1 != CNT_MAX)) stall_cnt1 <= stall_cnt1 + CNT_ONE;
    end
  end
`else
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
`endif

endmodule

// File: tb/tb_vscale_hasti_sram_arbiter.sv
// tb/tb_vscale_hasti_sram_arbiter.sv - scoreboard bench for vscale_hasti_sram_arbiter
module tb_vscale_hasti_sram_arbiter;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hresetn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [1:0]  s_htrans;
  logic        s_hready, s_hresp;
  logic [31:0] stall_cnt0, stall_cnt1;

  vscale_hasti_sram_arbiter dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_htrans(s_htrans),
    .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // SRAM model: one-cycle address/data pipeline.
  logic [31:0] mem [0:255];
  logic        dph_valid = 1'b0;
  logic        dph_write = 1'b0;
  logic [31:0] dph_addr  = 32'h0;
  always @(posedge hclk) begin
    if (s_hready) begin
      if (dph_valid && dph_write) mem[dph_addr[9:2]] <= s_hwdata;
      dph_valid <= s_htrans[1];
      dph_write <= s_hwrite;
      dph_addr  <= s_haddr;
    end
  end
  assign s_hrdata = (dph_valid && !dph_write) ? mem[dph_addr[9:2]] : 32'h0;

  // Grant scoreboard: expected SRAM addresses in grant order.
  logic [31:0] exp_q[$];
  int g0 = 0;
  int g1 = 0;
  always @(negedge hclk) begin
    if (s_htrans == 2'b10) begin
      if (exp_q.size() == 0) check("grant_unexpected", s_haddr, 32'hFFFF_FFFF);
      else check("grant_addr", s_haddr, exp_q.pop_front());
      if (s_haddr[13]) g1++;
      else g0++;
    end
  end

  // Simple masters: issue rem reads at consecutive addresses, advancing when hready was high.
  int          rem0 = 0, rem1 = 0;
  int          low0 = 0, low1 = 0;
  logic [31:0] a0, a1;
  logic        rdy0, rdy1;

  task automatic drive_masters();
    m0_htrans = (rem0 > 0) ? 2'b10 : 2'b00;
    m1_htrans = (rem1 > 0) ? 2'b10 : 2'b00;
    m0_haddr  = a0;
    m1_haddr  = a1;
  endtask

  task automatic start(input int n0, input int n1);
    rem0 = n0; rem1 = n1;
    a0 = 32'h1000; a1 = 32'h2000;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0;
    drive_masters();
  endtask

  // Entered and left at posedge+2.
  task automatic cycle();
    #1;
    rdy0 = m0_hready; rdy1 = m1_hready;
    if (!rdy0) low0++;
    if (!rdy1) low1++;
    @(posedge hclk); #1;
    if (m0_htrans == 2'b10 && rdy0) begin rem0--; a0 += 4; end
    if (m1_htrans == 2'b10 && rdy1) begin rem1--; a1 += 4; end
    drive_masters();
    #1;
  endtask

  task automatic reset_pulse();
    hresetn = 1'b0;
    rem0 = 0; rem1 = 0;
    drive_masters();
    @(posedge hclk); #2;
    hresetn = 1'b1;
  endtask

  initial begin
    hresetn = 1'b0; s_hready = 1'b1; s_hresp = 1'b0;
    a0 = 32'h40; a1 = 32'h80;
    m0_htrans = 2'b10; m1_htrans = 2'b10; m0_haddr = a0; m1_haddr = a1;
    m0_hwrite = 1'b1; m1_hwrite = 1'b1; m0_hsize = 3'b010; m1_hsize = 3'b010;
    m0_hwdata = 32'hA5A5_A5A5; m1_hwdata = 32'h5A5A_5A5A;
    repeat (2) @(posedge hclk);
    #2;
    s_hresp = 1'b1;
    check("rst_htrans", {30'h0, s_htrans}, 32'h0);
    check("rst_m0_hready", {31'h0, m0_hready}, 32'h1);
    check("rst_m1_hready", {31'h0, m1_hready}, 32'h1);
    check("rst_m0_hresp", {31'h0, m0_hresp}, 32'h0);
    check("rst_hwdata", s_hwdata, 32'h0);
    check("rst_stall0", stall_cnt0, 32'h0);
    check("rst_stall1", stall_cnt1, 32'h0);
    s_hresp = 1'b0;
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    reset_pulse();

    // M0 alone: write 0x100 then read it back
    @(posedge hclk); #1;
    m0_htrans = 2'b10; m0_haddr = 32'h100; m0_hwrite = 1'b1;
    exp_q.push_back(32'h100);
    #1;
    check("wr_htrans", {30'h0, s_htrans}, 32'h2);
    check("wr_hwrite", {31'h0, s_hwrite}, 32'h1);
    check("wr_hsize", {29'h0, s_hsize}, 32'h2);
    check("wr_m0_hready", {31'h0, m0_hready}, 32'h1);
    @(posedge hclk); #1;
    m0_hwdata = 32'hDEAD_BEEF; m0_hwrite = 1'b0; s_hresp = 1'b1;
    exp_q.push_back(32'h100);
    #1;
    check("rd_htrans", {30'h0, s_htrans}, 32'h2);
    check("rd_hwrite", {31'h0, s_hwrite}, 32'h0);
    check("wr_hwdata", s_hwdata, 32'hDEAD_BEEF);
    check("rd_m0_hready", {31'h0, m0_hready}, 32'h1);
    check("m0_hresp_owner", {31'h0, m0_hresp}, 32'h1);
    check("m1_hresp_nonowner", {31'h0, m1_hresp}, 32'h0);
    s_hresp = 1'b0;
    @(posedge hclk); #1;
    m0_htrans = 2'b00;
    #1;
    check("m0_hrdata", m0_hrdata, 32'hDEAD_BEEF);
    check("m1_hrdata_bcast", m1_hrdata, 32'hDEAD_BEEF);
    check("dph_m0_hready", {31'h0, m0_hready}, 32'h1);

    // First contention after reset: M0 then M1, M1 stalls one cycle
    reset_pulse();
    low0 = 0; low1 = 0;
    start(1, 1);
    exp_q.push_back(32'h1000); exp_q.push_back(32'h2000);
    repeat (4) cycle();
    check("contend_m1_low", low1, 1);
    check("contend_m0_low", low0, 0);

    // Continuous contention: strict alternation, four grants each
    reset_pulse();
    g0 = 0; g1 = 0;
    start(4, 4);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h1000 + 4 * k);
      exp_q.push_back(32'h2000 + 4 * k);
    end
    repeat (10) cycle();
    check("rr_grants_m0", g0, 4);
    check("rr_grants_m1", g1, 4);
    check("rr_drained", exp_q.size(), 0);
`ifdef VSCALE_ARB_PERF_EN
    check("stall_cnt0", stall_cnt0, 3);
    check("stall_cnt1", stall_cnt1, 4);
`else
    check("stall_cnt0", stall_cnt0, 0);
    check("stall_cnt1", stall_cnt1, 0);
`endif

    // SRAM not ready for 3 cycles with both requesting
    s_hready = 1'b0;
    start(1, 1);
    m0_hwdata = 32'h5555_5555; m1_hwdata = 32'h6666_6666;
    exp_q.push_back(32'h1000); exp_q.push_back(32'h2000);
    repeat (3) cycle();
    s_hresp = 1'b1;
    check("stall_m0_hready", {31'h0, m0_hready}, 32'h0);
    check("stall_m1_hready", {31'h0, m1_hready}, 32'h0);
    check("stall_htrans", {30'h0, s_htrans}, 32'h0);
    check("stall_hwdata", s_hwdata, 32'h0);
    check("stall_m0_hresp", {31'h0, m0_hresp}, 32'h0);
    s_hresp = 1'b0;
    s_hready = 1'b1;
    repeat (3) cycle();
    check("resume_drained", exp_q.size(), 0);

    // Reset asserted while M1 is parked
    low0 = 0; low1 = 0;
    start(1, 1);
    exp_q.push_back(32'h1000);
    cycle();
    check("pend1_set", {31'h0, m1_hready}, 32'h0);
    hresetn = 1'b0;
    #1;
    check("async_htrans", {30'h0, s_htrans}, 32'h0);
    check("async_m1_hready", {31'h0, m1_hready}, 32'h1);
    @(posedge hclk); #2;
    hresetn = 1'b1;
    repeat (3) cycle();
    check("post_rst_m1_hready", {31'h0, m1_hready}, 32'h1);
    check("post_rst_stall1", stall_cnt1, 32'h0);
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vscale_hasti_sram_arbiter.md
VSCALE_HASTI_SRAM_ARBITER -- requirements
Module: vscale_hasti_sram_arbiter

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of each stall counter.
REQ-002 SHALL have port: hclk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port: hresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: m0_haddr/m1_haddr  input  32  master address.
REQ-005 SHALL have ports: m0_hwrite/m1_hwrite  input  1  master write flag.
REQ-006 SHALL have ports: m0_hsize/m1_hsize  input  3  master transfer size.
REQ-007 SHALL have ports: m0_htrans/m1_htrans  input  2  master transfer type.
REQ-008 SHALL have ports: m0_hwdata/m1_hwdata  input  32  master write data.
REQ-009 SHALL have ports: m0_hrdata/m1_hrdata  output  32  read data.
REQ-010 SHALL have ports: m0_hready/m1_hready  output  1  master ready.
REQ-011 SHALL have ports: m0_hresp/m1_hresp  output  1  master response.
REQ-012 SHALL have ports: s_haddr (output, 32), s_hwrite (output, 1), s_hsize (output, 3), s_htrans (output, 2), s_hwdata (output, 32): SRAM-side request.
REQ-013 SHALL have ports: s_hrdata (input, 32), s_hready (input, 1), s_hresp (input, 1): SRAM-side response.
REQ-014 SHALL have ports: stall_cnt0/stall_cnt1  output  CNT_W  per-master stall-cycle counts.

Function
REQ-015 SHALL treat master i as requesting when pend_i=1, or when mi_htrans[1]=1 and mi_hready=1 in the same cycle.
REQ-016 SHALL source a request from the pend_i holding registers (addr, write, size) when pend_i=1; otherwise from the live bus.
REQ-017 SHALL issue a grant only while s_hready=1: a single requester wins; under contention, the master other than last_grant wins.
REQ-018 SHALL drive s_haddr/s_hwrite/s_hsize from the granted source with s_htrans=NONSEQ; with no grant it SHALL drive s_htrans=IDLE. SEQ requests are forwarded as NONSEQ singles.
REQ-019 SHALL latch a live request that is not granted into pend_i at the clock edge, and SHALL clear pend_i when its request is granted.
REQ-020 SHALL update last_grant on every grant; dph_owner SHALL become the granted master (or NONE) at each edge where s_hready=1, and SHALL hold while s_hready=0.
REQ-021 SHALL drive mi_hready = !pend_i && (dph_owner!=i || s_hready).
REQ-022 SHALL route s_hwdata from dph_owner's hwdata, or 0 when dph_owner is NONE.
REQ-023 SHALL route s_hresp to dph_owner; the non-owner SHALL see OKAY. s_hrdata SHALL be broadcast to both masters.
REQ-024 SHALL add zero latency for an uncontended request (address to SRAM in the same cycle); each lost arbitration SHALL add 1 cycle.
REQ-025 SHALL NOT let a master stalled in its data phase (mi_hready=0) present a new live request.

Reset
REQ-026 SHALL clear, asynchronously on hresetn=0: pend0=pend1=0, dph_owner=NONE, last_grant=M1 (M0 wins first contention), stall counters=0.
REQ-027 SHALL hold these values during reset: s_htrans=IDLE, m0_hready=m1_hready=1, hresp=OKAY, s_hwdata=0.
REQ-028 SHALL discard pending requests when reset asserts mid-operation; no replay after release.

Configuration
REQ-029 SHALL, with VSCALE_ARB_PERF_EN defined, increment stall_cnti in every cycle where pend_i=1, saturating at all-ones.
REQ-030 SHALL, without VSCALE_ARB_PERF_EN, tie stall_cnt0/stall_cnt1 to 0 and include no counter logic.

Verification
REQ-031 SHALL cover: M0 alone, NONSEQ write 0x100=0xDEADBEEF then read 0x100 -> s_htrans NONSEQ same cycle, m0_hrdata=0xDEADBEEF, m0_hready never low.
REQ-032 SHALL cover: M0 and M1 both NONSEQ in cycle 1 after reset -> M0 granted cycle 1, M1 granted cycle 2, m1_hready=0 exactly 1 cycle.
REQ-033 SHALL cover: both masters requesting continuously for 8 cycles -> grants strictly alternate M0,M1,...; each master gets 4 grants.
REQ-034 SHALL cover: s_hready held 0 for 3 cycles with both requesting -> no grant, dph_owner unchanged, both pend set; service resumes round-robin.
REQ-035 SHALL cover: hresetn pulsed low while pend1=1 -> pend1=0, s_htrans=IDLE, m1_hready=1 immediately (asynchronous).
REQ-036 SHALL cover: VSCALE_ARB_PERF_EN defined with the REQ-033 stimulus -> stall_cnt0 and stall_cnt1 each increment once per lost grant; undefined -> both read 0.
